// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - handshake, config and serial-line bundle for uart_tx_frame
//
// Signals:
//   P_DATA      word to send (DATA_WIDTH bits)
//   DATA_VALID  send request, sampled on the rising bit-clock edge
//   PAR_EN      insert a parity bit after the data bits
//   PAR_TYP     0 = even parity, 1 = odd parity
//   STOP2       0 = one stop bit, 1 = two stop bits
//   TX_OUT      registered serial line, idle high
//   Busy        registered, high while a frame is in progress
// Modports: master drives the request side, slave is the frame engine.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        output STOP2,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        input  STOP2,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit frame engine: start, data, optional parity, 1 or 2 stop bits
//
// Ports:
//   CLK  TX bit clock, one serial bit per rising edge
//   RST  asynchronous active-low reset
//   bus  uart_tx_frame_if.slave: P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2 in;
//        TX_OUT, Busy out (both registered)
// Parameters:
//   DATA_WIDTH  payload bits per frame (5..16); must match the interface width
//   MSB_FIRST   0 = bit 0 sent first, 1 = bit DATA_WIDTH-1 sent first
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_frame_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         bit_cnt;
    logic [CW-1:0]         bit_cnt_next;
    logic [CW-1:0]         bit_cnt_inc;
    logic                  tx_r;
    logic                  tx_next;
    logic                  busy_r;
    logic                  busy_next;
    logic                  capture;
    logic                  try_accept;

    // Frame configuration frozen at accept time; inputs are ignored afterwards.
    logic [DATA_WIDTH-1:0] data_r;
    logic                  par_bit_r;
    logic                  par_en_r;
    logic                  stop2_r;

    // Maps the transmit-order position to the payload bit index.
    function automatic logic [CW-1:0] bit_index(input logic [CW-1:0] pos);
        if (MSB_FIRST)
            bit_index = LAST_BIT - pos;
        else
            bit_index = pos;
    endfunction

    assign bit_cnt_inc = bit_cnt + CW'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            tx_r    <= tx_next;
            busy_r  <= busy_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_r    <= '0;
            par_bit_r <= 1'b0;
            par_en_r  <= 1'b0;
            stop2_r   <= 1'b0;
        end else if (capture) begin
            data_r    <= bus.P_DATA;
            // Odd parity is the inverted even parity of the payload.
            par_bit_r <= (^bus.P_DATA) ^ bus.PAR_TYP;
            par_en_r  <= bus.PAR_EN;
            stop2_r   <= bus.STOP2;
        end
    end

    // Next-state logic. TX_OUT is registered from the state being entered,
    // so each branch sets the line level for the upcoming bit.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        tx_next      = 1'b1;
        busy_next    = 1'b1;
        capture      = 1'b0;
        try_accept   = 1'b0;

        case (state)
            ST_IDLE: begin
                try_accept = 1'b1;
            end
            ST_START: begin
                state_next   = ST_DATA;
                bit_cnt_next = '0;
                tx_next      = data_r[bit_index('0)];
            end
            ST_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_next = '0;
                    if (par_en_r) begin
                        state_next = ST_PARITY;
                        tx_next    = par_bit_r;
                    end else begin
                        state_next = ST_STOP1;
                        tx_next    = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_inc;
                    tx_next      = data_r[bit_index(bit_cnt_inc)];
                end
            end
            ST_PARITY: begin
                state_next = ST_STOP1;
            end
            ST_STOP1: begin
                if (stop2_r)
                    state_next = ST_STOP2;
                else
                    try_accept = 1'b1;
            end
            ST_STOP2: begin
                try_accept = 1'b1;
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = '0;
                busy_next    = 1'b0;
            end
        endcase

        // Shared by IDLE and the last stop cycle: a pending request starts a
        // frame on this edge, giving back-to-back frames with no idle gap.
        if (try_accept) begin
            bit_cnt_next = '0;
            if (bus.DATA_VALID) begin
                capture    = 1'b1;
                state_next = ST_START;
                tx_next    = 1'b0;
                busy_next  = 1'b1;
            end else begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        end
    end

    assign bus.TX_OUT = tx_r;
    assign bus.Busy   = busy_r;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame (8-bit LSB-first and 7-bit MSB-first)
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_WIDTH(8)) if8();
    uart_tx_frame_if #(.DATA_WIDTH(7)) if7();

    uart_tx_frame #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .CLK (clk),
        .RST (rst_n),
        .bus (if8.slave)
    );

    uart_tx_frame #(.DATA_WIDTH(7), .MSB_FIRST(1'b1)) dut7 (
        .CLK (clk),
        .RST (rst_n),
        .bus (if7.slave)
    );

    int checks = 0;
    int failures = 0;
    bit exp_q[$];

    typedef struct {
        bit          which;
        logic [15:0] data;
        bit          pen;
        bit          ptyp;
        bit          s2;
        int          len;
        logic [15:0] bits;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_tx(input bit which);
        return which ? if7.TX_OUT : if8.TX_OUT;
    endfunction

    function automatic logic get_busy(input bit which);
        return which ? if7.Busy : if8.Busy;
    endfunction

    task automatic drive(input bit which, input bit dv, input logic [15:0] d,
                         input bit pen, input bit ptyp, input bit s2);
        if (which) begin
            if7.DATA_VALID = dv; if7.P_DATA = d[6:0];
            if7.PAR_EN = pen; if7.PAR_TYP = ptyp; if7.STOP2 = s2;
        end else begin
            if8.DATA_VALID = dv; if8.P_DATA = d[7:0];
            if8.PAR_EN = pen; if8.PAR_TYP = ptyp; if8.STOP2 = s2;
        end
    endtask

    task automatic set_dv(input bit which, input bit dv);
        if (which) if7.DATA_VALID = dv;
        else       if8.DATA_VALID = dv;
    endtask

    // Change word and config (not the request) while a frame is in flight.
    task automatic scramble(input bit which);
        logic [15:0] d;
        d = 16'($urandom);
        if (which) begin
            if7.P_DATA = d[6:0]; if7.PAR_EN = 1'($urandom);
            if7.PAR_TYP = 1'($urandom); if7.STOP2 = 1'($urandom);
        end else begin
            if8.P_DATA = d[7:0]; if8.PAR_EN = 1'($urandom);
            if8.PAR_TYP = 1'($urandom); if8.STOP2 = 1'($urandom);
        end
    endtask

    // Reference: the line sequence of one frame, built straight from the frame rules.
    task automatic append_frame(input int w, input bit msb, input logic [15:0] d,
                                input bit pen, input bit ptyp, input bit s2);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            exp_q.push_back(d[msb ? (w - 1 - i) : i]);
            if (d[i]) ones++;
        end
        if (pen) exp_q.push_back(((ones % 2) == 1) ^ ptyp);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
    endtask

    // Called at the first negedge after the accept edge; walks exp_q then
    // checks two idle cycles.
    task automatic check_q(input bit which, input string name, input int drop_at,
                           input int pulse_at, input bit do_scramble);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({name, " tx"}, get_tx(which), exp_q[i]);
            chk({name, " busy"}, get_busy(which), 1'b1);
            if (do_scramble && i == 1) scramble(which);
            if (i == drop_at) set_dv(which, 1'b0);
            if (pulse_at >= 0 && i == pulse_at) set_dv(which, 1'b1);
            if (pulse_at >= 0 && i == pulse_at + 1) set_dv(which, 1'b0);
            @(negedge clk);
        end
        for (int j = 0; j < 2; j++) begin
            chk({name, " idle tx"}, get_tx(which), 1'b1);
            chk({name, " idle busy"}, get_busy(which), 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic send(input bit which, input logic [15:0] d, input bit pen,
                        input bit ptyp, input bit s2);
        drive(which, 1'b1, d, pen, ptyp, s2);
        @(negedge clk);
        set_dv(which, 1'b0);
    endtask

    initial begin
        logic [15:0] d;
        bit pen, ptyp, s2, w7;

        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Expected line sequences written in transmit order, first bit leftmost.
        tbl[0] = '{1'b0, 16'h00A5, 1'b1, 1'b0, 1'b0, 11, 16'b01010010101};
        tbl[1] = '{1'b0, 16'h00A5, 1'b1, 1'b1, 1'b0, 11, 16'b01010010111};
        tbl[2] = '{1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0, 10, 16'b0101001011};
        tbl[3] = '{1'b0, 16'h00A5, 1'b1, 1'b0, 1'b1, 12, 16'b010100101011};
        tbl[4] = '{1'b1, 16'h0041, 1'b0, 1'b0, 1'b0,  9, 16'b010000011};
        tbl[5] = '{1'b1, 16'h0041, 1'b1, 1'b1, 1'b1, 11, 16'b01000001111};

        // Reset and idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset tx8", if8.TX_OUT, 1'b1);
            chk("reset busy8", if8.Busy, 1'b0);
            chk("reset tx7", if7.TX_OUT, 1'b1);
            chk("reset busy7", if7.Busy, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle tx8", if8.TX_OUT, 1'b1);
            chk("idle busy8", if8.Busy, 1'b0);
            chk("idle tx7", if7.TX_OUT, 1'b1);
            chk("idle busy7", if7.Busy, 1'b0);
        end

        // Directed table; inputs are scrambled mid-frame by check_q.
        for (int v = 0; v < 6; v++) begin
            send(tbl[v].which, tbl[v].data, tbl[v].pen, tbl[v].ptyp, tbl[v].s2);
            exp_q.delete();
            for (int i = 0; i < tbl[v].len; i++)
                exp_q.push_back(tbl[v].bits[tbl[v].len - 1 - i]);
            check_q(tbl[v].which, $sformatf("table%0d", v), -1, -1, 1'b1);
        end

        // Back-to-back: request held high across 8'h55 then 8'hFF.
        exp_q.delete();
        append_frame(8, 1'b0, 16'h0055, 1'b1, 1'b0, 1'b0);
        append_frame(8, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        if8.P_DATA = 8'hFF;
        check_q(1'b0, "b2b", 11, -1, 1'b0);

        // Request pulse during a data bit must not start another frame.
        exp_q.delete();
        append_frame(8, 1'b0, 16'h0033, 1'b0, 1'b0, 1'b0);
        send(1'b0, 16'h0033, 1'b0, 1'b0, 1'b0);
        check_q(1'b0, "pulse", -1, 4, 1'b0);

        // Reset during data bit 3 of 8'h00.
        send(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("abort pre tx", if8.TX_OUT, 1'b0);
            chk("abort pre busy", if8.Busy, 1'b1);
            if (i < 4) @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort tx", if8.TX_OUT, 1'b1);
        chk("abort busy", if8.Busy, 1'b0);
        @(negedge clk);
        chk("abort hold tx", if8.TX_OUT, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort idle busy", if8.Busy, 1'b0);
        exp_q.delete();
        append_frame(8, 1'b0, 16'h00C3, 1'b1, 1'b1, 1'b1);
        send(1'b0, 16'h00C3, 1'b1, 1'b1, 1'b1);
        check_q(1'b0, "after abort", -1, -1, 1'b0);

        // Randomized frames against the reference model.
        for (int n = 0; n < 30; n++) begin
            w7   = (n % 3 == 2);
            d    = 16'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            s2   = 1'($urandom);
            exp_q.delete();
            append_frame(w7 ? 7 : 8, w7, d, pen, ptyp, s2);
            send(w7, d, pen, ptyp, s2);
            check_q(w7, $sformatf("rand%0d", n), -1, -1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
